hilo_muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the MIPS core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the exec stage and runs an iterative shift-add multiplier or restoring divider over 32 steps. It raises busy so the CPU state machine stalls MFHI/MFLO and further HI/LO ops until results are committed. The combinational ALU keeps all other ops and reads hi/lo from this block.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/muldiv_sign_fix.sv | 26 ++
 rtl/hilo_muldiv_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared types and constants for the HI/LO multiply/divide
//                sequencer (operation codes, sequencer states, datapath width).
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int MULDIV_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } muldiv_state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_sign_fix.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_sign_fix
//  Description : Conditional two's-complement negation. Produces |x| when neg
//                is the operand sign bit, or applies a result sign when neg is
//                the sign correction flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  // Negate when requested, otherwise pass through unchanged.
  always_comb begin
    res = val;
    if (neg) begin
      res = ~val + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_muldiv_ctrl
//  Description : Owns the HI/LO register pair. Runs MULT/MULTU as a WIDTH-step
//                shift-add multiplier and DIV/DIVU as a WIDTH-step restoring
//                divider on operand magnitudes, then applies signs in FIX.
//                MTHI/MTLO write directly from IDLE without raising busy.
//                Build option: define MULDIV_FAST_MULT_EN to compute products
//                combinationally in IDLE and go straight to FIX.
//  Revision    : 1.0 - initial release
// ============================================================================
module hilo_muldiv_ctrl
  import mips_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  muldiv_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Multiply: full product register. Divide: low half holds the dividend
  // being shifted out and the quotient being shifted in.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // Partial remainder for the divider (one spare bit for the trial subtract).
  logic [WIDTH:0]     rem_q, rem_d;
  // Multiplicand magnitude for MULT*, divisor magnitude for DIV*.
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               is_div_q, is_div_d;
  // Sign of the product/quotient and sign of the remainder.
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               op_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_shift, div_diff;
  logic               div_nb;
  logic [WIDTH:0]     div_rem_next;
  logic [WIDTH-1:0]   div_quo_next;

  assign op_signed = (op == OP_MULT) || (op == OP_DIV);

  // Operand magnitudes taken at latch time (raw values for unsigned ops).
  muldiv_sign_fix #(.W(WIDTH)) u_abs_a (
    .val (a),
    .neg (op_signed & a[WIDTH-1]),
    .res (a_mag)
  );

  muldiv_sign_fix #(.W(WIDTH)) u_abs_b (
    .val (b),
    .neg (op_signed & b[WIDTH-1]),
    .res (b_mag)
  );

  // Result sign correction applied in FIX.
  muldiv_sign_fix #(.W(2*WIDTH)) u_fix_prod (
    .val (acc_q),
    .neg (neg_res_q),
    .res (prod_fix)
  );

  muldiv_sign_fix #(.W(WIDTH)) u_fix_quo (
    .val (acc_q[WIDTH-1:0]),
    .neg (neg_res_q),
    .res (quo_fix)
  );

  muldiv_sign_fix #(.W(WIDTH)) u_fix_rem (
    .val (rem_q[WIDTH-1:0]),
    .neg (neg_rem_q),
    .res (rem_fix)
  );

  // One shift-add multiply step and one restoring divide step.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    if (acc_q[0]) begin
      mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    end
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    div_shift    = {rem_q, acc_q[WIDTH-1]};
    div_diff     = div_shift - {2'b00, mcand_q};
    div_nb       = ~div_diff[WIDTH+1];
    div_rem_next = div_nb ? div_diff[WIDTH:0] : div_shift[WIDTH:0];
    div_quo_next = {acc_q[WIDTH-2:0], div_nb};
  end

  // Sequencer next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    mcand_d   = mcand_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MTHI: begin
              hi_d   = a;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = a;
              done_d = 1'b1;
            end
            OP_MULT, OP_MULTU: begin
              mcand_d   = a_mag;
              is_div_d  = 1'b0;
              neg_res_d = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_rem_d = 1'b0;
              rem_d     = '0;
              cnt_d     = '0;
`ifdef MULDIV_FAST_MULT_EN
              acc_d     = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
              state_d   = ST_FIX;
`else
              acc_d     = {{WIDTH{1'b0}}, b_mag};
              state_d   = ST_ITER;
`endif
            end
            OP_DIV, OP_DIVU: begin
              mcand_d   = b_mag;
              acc_d     = {{WIDTH{1'b0}}, a_mag};
              rem_d     = '0;
              is_div_d  = 1'b1;
              // A zero divisor must leave the all-ones quotient unsigned.
              neg_res_d = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]) & (b != '0);
              neg_rem_d = op_signed & a[WIDTH-1];
              cnt_d     = '0;
              state_d   = ST_ITER;
            end
            default: ;
          endcase
        end
      end

      ST_ITER: begin
        if (is_div_q) begin
          acc_d = {acc_q[2*WIDTH-1:WIDTH], div_quo_next};
          rem_d = div_rem_next;
        end else begin
          acc_d = mul_next;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        if (is_div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      mcand_q   <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      mcand_q   <= mcand_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_muldiv_ctrl
//  Description : Directed self-checking bench for hilo_muldiv_ctrl with
//                hand-computed HI/LO results, latency and busy-length checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_muldiv_ctrl;
  import mips_pkg::*;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT  = 2;
  localparam int MUL_BUSY = 1;
`else
  localparam int MUL_LAT  = 34;
  localparam int MUL_BUSY = 33;
`endif
  localparam int DIV_LAT  = 34;
  localparam int DIV_BUSY = 33;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  muldiv_op_t  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  hilo_muldiv_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue an op in the current cycle and follow it to its done pulse.
  task automatic run_op(input string tag, input muldiv_op_t o,
                        input logic [31:0] av, input logic [31:0] bv,
                        input int exp_lat, input int exp_busy,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    int bcnt;
    start = 1'b1; op = o; a = av; b = bv;
    tick();
    start = 1'b0;
    lat  = 1;
    bcnt = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) bcnt++;
      tick();
      lat++;
    end
    check({tag, "_lat"},  64'(lat),  64'(exp_lat));
    check({tag, "_busy"}, 64'(bcnt), 64'(exp_busy));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    int lat;
    reset = 1'b1; start = 1'b0; op = OP_MULTU; a = '0; b = '0;
    tick();
    tick();
    check("rst_hi",   64'(hi),   64'd0);
    check("rst_lo",   64'(lo),   64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    reset = 1'b0;
    tick();

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, MUL_BUSY,
           32'hFFFF_FFFE, 32'h0000_0001);
    // Back-to-back issues below start in the cycle where done is high.
    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, MUL_LAT, MUL_BUSY,
           32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, DIV_LAT, DIV_BUSY,
           32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", OP_DIVU, 32'd100, 32'd7, DIV_LAT, DIV_BUSY, 32'd2, 32'd14);
    run_op("divu_by0", OP_DIVU, 32'd100, 32'd0, DIV_LAT, DIV_BUSY,
           32'd100, 32'hFFFF_FFFF);
    run_op("div_by0", OP_DIV, 32'hFFFF_FFFB, 32'd0, DIV_LAT, DIV_BUSY,
           32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, DIV_BUSY,
           32'd0, 32'h8000_0000);

    // MTHI: written at next edge, done in the following cycle, never busy.
    start = 1'b1; op = OP_MTHI; a = 32'h1234; b = 32'd0;
    check("mthi_busy_n", 64'(busy), 64'd0);
    tick();
    start = 1'b0;
    check("mthi_hi",      64'(hi),   64'h1234);
    check("mthi_lo_keep", 64'(lo),   64'h8000_0000);
    check("mthi_done",    64'(done), 64'd1);
    check("mthi_busy",    64'(busy), 64'd0);
    tick();
    check("mthi_done_clr", 64'(done), 64'd0);

    start = 1'b1; op = OP_MTLO; a = 32'h55; b = 32'd0;
    tick();
    start = 1'b0;
    check("mtlo_lo",      64'(lo), 64'h55);
    check("mtlo_hi_keep", 64'(hi), 64'h1234);
    tick();

    // A start pulse while busy must be dropped without disturbing the op.
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      if (lat == 5) begin
        start = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd2;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    check("ign_lat", 64'(lat), 64'(DIV_LAT));
    check("ign_hi",  64'(hi),  64'd2);
    check("ign_lo",  64'(lo),  64'd14);
    tick();
    check("ign_no_second", 64'(busy), 64'd0);
    tick();

    // Reset during ITER step 10 aborts the divide and zeroes HI/LO.
    start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("abort_busy_pre", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    check("abort_hi",   64'(hi),   64'd0);
    check("abort_lo",   64'(lo),   64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    reset = 1'b0;
    tick();
    run_op("multu_3x5", OP_MULTU, 32'd3, 32'd5, MUL_LAT, MUL_BUSY, 32'd0, 32'd15);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
